// File: rtl/mux_arb_2t1.sv
// Round-robin owner arbiter for a shared 2:1 data mux: grants one of two
// requesters, drives SEL from the owner state and registers each transferred word.
module mux_arb_2t1 #(
    parameter int n        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         REQ0,
    input  logic         REQ1,
    input  logic [n-1:0] D0,
    input  logic [n-1:0] D1,
    output logic         GNT0,
    output logic         GNT1,
    output logic         SEL,
    output logic [n-1:0] D_OUT,
    output logic         VALID,
    output logic         SRC,
    output logic         BUSY
);

    localparam int            HW   = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic          last_reg, last_next;
    logic [HW-1:0] hcnt_reg, hcnt_next;
    logic [n-1:0]  d_out_reg;
    logic          valid_reg;
    logic          src_reg;

    logic          own_sel;
    logic          xfer;
    logic [n-1:0]  mux_word;

    assign own_sel = (state_reg == OWN1);
    assign xfer    = ((state_reg == OWN0) && REQ0) || ((state_reg == OWN1) && REQ1);

    // The shared mux itself, steered only by the registered owner.
    genvar gi;
    generate
        for (gi = 0; gi < n; gi++) begin : g_mux
            assign mux_word[gi] = own_sel ? D1[gi] : D0[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        hcnt_next  = hcnt_reg;
        case (state_reg)
            IDLE: begin
                hcnt_next = '0;
                if (REQ0 && REQ1) begin
                    state_next = last_reg ? OWN0 : OWN1;
                end else if (REQ0) begin
                    state_next = OWN0;
                end else if (REQ1) begin
                    state_next = OWN1;
                end
            end
            OWN0: begin
                if (REQ0) begin
                    if ((hcnt_reg == HMAX) && REQ1) begin
                        state_next = OWN1;
                        hcnt_next  = '0;
                        last_next  = 1'b0;
                    end else if (hcnt_reg != HMAX) begin
                        hcnt_next = hcnt_reg + 1'b1;
                    end
                end else begin
                    state_next = REQ1 ? OWN1 : IDLE;
                    hcnt_next  = '0;
                    last_next  = 1'b0;
                end
            end
            OWN1: begin
                if (REQ1) begin
                    if ((hcnt_reg == HMAX) && REQ0) begin
                        state_next = OWN0;
                        hcnt_next  = '0;
                        last_next  = 1'b1;
                    end else if (hcnt_reg != HMAX) begin
                        hcnt_next = hcnt_reg + 1'b1;
                    end
                end else begin
                    state_next = REQ0 ? OWN0 : IDLE;
                    hcnt_next  = '0;
                    last_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                hcnt_next  = '0;
            end
        endcase
    end

    // LAST resets to 1 so the first tie after reset goes to source 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            hcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            hcnt_reg  <= hcnt_next;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            d_out_reg <= '0;
            valid_reg <= 1'b0;
            src_reg   <= 1'b0;
        end else begin
            valid_reg <= xfer;
            if (xfer) begin
                d_out_reg <= mux_word;
                src_reg   <= own_sel;
            end
        end
    end

    assign GNT0  = (state_reg == OWN0);
    assign GNT1  = (state_reg == OWN1);
    assign SEL   = own_sel;
    assign BUSY  = (state_reg != IDLE);
    assign D_OUT = d_out_reg;
    assign VALID = valid_reg;
    assign SRC   = src_reg;

endmodule

// File: tb/tb_mux_arb_2t1.sv
// Scoreboard bench for mux_arb_2t1: stimulus pushes expected {src,data}
// words, negedge monitors pop and compare on every VALID strobe.
module tb_mux_arb_2t1;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       RST_N1 = 1'b0;
    logic       REQ0 = 1'b0;
    logic       REQ1 = 1'b0;
    logic [7:0] D0 = 8'h00;
    logic [7:0] D1 = 8'h00;

    logic       GNT0, GNT1, SEL, VALID, SRC, BUSY;
    logic [7:0] D_OUT;
    logic       GNT0_1, GNT1_1, SEL_1, VALID_1, SRC_1, BUSY_1;
    logic [7:0] D_OUT_1;

    int total = 0;
    int bad   = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] exp0, exp1;

    mux_arb_2t1 #(.n(8), .MAX_HOLD(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ0(REQ0), .REQ1(REQ1), .D0(D0), .D1(D1),
        .GNT0(GNT0), .GNT1(GNT1), .SEL(SEL), .D_OUT(D_OUT), .VALID(VALID),
        .SRC(SRC), .BUSY(BUSY)
    );

    mux_arb_2t1 #(.n(8), .MAX_HOLD(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N1), .REQ0(REQ0), .REQ1(REQ1), .D0(D0), .D1(D1),
        .GNT0(GNT0_1), .GNT1(GNT1_1), .SEL(SEL_1), .D_OUT(D_OUT_1), .VALID(VALID_1),
        .SRC(SRC_1), .BUSY(BUSY_1)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        @(posedge CLK);
        #2 RST_N = 1'b0;
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        tick();
        RST_N = 1'b1;
    endtask

    always @(negedge CLK) begin
        if (VALID) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid actual=src%0d/%0h required=none", SRC, D_OUT);
            end else begin
                exp0 = q0.pop_front();
                chk("dout", {24'd0, D_OUT}, {24'd0, exp0[7:0]});
                chk("src", {31'd0, SRC}, {31'd0, exp0[8]});
                $display("txn mh4 src=%0d data=%02h", SRC, D_OUT);
            end
        end
    end

    always @(negedge CLK) begin
        if (VALID_1) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid1 actual=src%0d/%0h required=none", SRC_1, D_OUT_1);
            end else begin
                exp1 = q1.pop_front();
                chk("dout1", {24'd0, D_OUT_1}, {24'd0, exp1[7:0]});
                chk("src1", {31'd0, SRC_1}, {31'd0, exp1[8]});
                $display("txn mh1 src=%0d data=%02h", SRC_1, D_OUT_1);
            end
        end
    end

    initial begin
        #3 RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
        chk("rst_gnt0", {31'd0, GNT0}, 0);
        chk("rst_gnt1", {31'd0, GNT1}, 0);
        chk("rst_sel", {31'd0, SEL}, 0);
        chk("rst_busy", {31'd0, BUSY}, 0);
        chk("rst_valid", {31'd0, VALID}, 0);
        chk("rst_dout", {24'd0, D_OUT}, 0);
        chk("rst_src", {31'd0, SRC}, 0);

        // Single requester: three words from source 0
        REQ0 = 1'b1;
        D0 = 8'h11;
        tick();
        chk("single_gnt0", {31'd0, GNT0}, 1);
        chk("single_valid0", {31'd0, VALID}, 0);
        q0.push_back({1'b0, 8'h11});
        tick();
        D0 = 8'h22;
        q0.push_back({1'b0, 8'h22});
        tick();
        D0 = 8'h33;
        q0.push_back({1'b0, 8'h33});
        tick();
        REQ0 = 1'b0;
        chk("single_hold_gnt0", {31'd0, GNT0}, 1);
        tick();
        chk("single_idle_busy", {31'd0, BUSY}, 0);
        chk("single_idle_valid", {31'd0, VALID}, 0);

        // Post-reset tie goes to source 0, then seamless handoff
        do_reset();
        REQ0 = 1'b1;
        REQ1 = 1'b1;
        D0 = 8'hA0;
        D1 = 8'hB0;
        tick();
        chk("tie_gnt0", {31'd0, GNT0}, 1);
        chk("tie_gnt1", {31'd0, GNT1}, 0);
        chk("tie_sel", {31'd0, SEL}, 0);
        q0.push_back({1'b0, 8'hA0});
        tick();
        REQ0 = 1'b0;
        tick();
        chk("handoff_gnt1", {31'd0, GNT1}, 1);
        chk("handoff_sel", {31'd0, SEL}, 1);
        chk("handoff_busy", {31'd0, BUSY}, 1);
        chk("handoff_valid", {31'd0, VALID}, 0);
        q0.push_back({1'b1, 8'hB0});
        tick();
        REQ1 = 1'b0;
        tick();
        chk("handoff_idle", {31'd0, BUSY}, 0);

        // Contention with MAX_HOLD=4: groups of four per source
        do_reset();
        REQ0 = 1'b1;
        REQ1 = 1'b1;
        D0 = 8'hC0;
        D1 = 8'hD1;
        tick();
        for (int i = 0; i < 16; i++) begin
            if (((i / 4) % 2) == 0) q0.push_back({1'b0, 8'hC0});
            else                    q0.push_back({1'b1, 8'hD1});
            tick();
            chk("cont_valid", {31'd0, VALID}, 1);
        end
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        tick();
        chk("cont_end_valid", {31'd0, VALID}, 0);

        // Saturation: lone source 1 is never preempted
        do_reset();
        REQ1 = 1'b1;
        tick();
        chk("sat_gnt1", {31'd0, GNT1}, 1);
        for (int i = 0; i < 10; i++) begin
            D1 = 8'hE0 + 8'(i);
            q0.push_back({1'b1, 8'hE0 + 8'(i)});
            tick();
            chk("sat_hold_gnt1", {31'd0, GNT1}, 1);
        end
        REQ0 = 1'b1;
        D0 = 8'hF0;
        D1 = 8'hEA;
        q0.push_back({1'b1, 8'hEA});
        tick();
        chk("sat_handoff_gnt0", {31'd0, GNT0}, 1);
        chk("sat_handoff_gnt1", {31'd0, GNT1}, 0);
        chk("sat_handoff_sel", {31'd0, SEL}, 0);
        REQ1 = 1'b0;
        q0.push_back({1'b0, 8'hF0});
        tick();
        REQ0 = 1'b0;
        tick();
        chk("sat_idle", {31'd0, BUSY}, 0);

        // Asynchronous reset in the middle of OWN1
        do_reset();
        REQ1 = 1'b1;
        D1 = 8'hA5;
        tick();
        tick();
        chk("arst_pre_dout", {24'd0, D_OUT}, 32'hA5);
        chk("arst_pre_gnt1", {31'd0, GNT1}, 1);
        #2 RST_N = 1'b0;
        #1;
        chk("arst_gnt1", {31'd0, GNT1}, 0);
        chk("arst_sel", {31'd0, SEL}, 0);
        chk("arst_valid", {31'd0, VALID}, 0);
        chk("arst_busy", {31'd0, BUSY}, 0);
        chk("arst_dout", {24'd0, D_OUT}, 0);
        REQ1 = 1'b0;
        tick();

        // MAX_HOLD=1 instance: strict alternation under contention
        RST_N1 = 1'b1;
        REQ0 = 1'b1;
        REQ1 = 1'b1;
        D0 = 8'h5A;
        D1 = 8'hA6;
        tick();
        chk("mh1_gnt0", {31'd0, GNT0_1}, 1);
        for (int i = 0; i < 8; i++) begin
            if ((i % 2) == 0) q1.push_back({1'b0, 8'h5A});
            else              q1.push_back({1'b1, 8'hA6});
            tick();
        end
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        tick();
        tick();
        chk("mh1_idle", {31'd0, BUSY_1}, 0);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
